// File: rtl/modred_v2.sv
// modred_v2: two-stage pipelined reducer modulo Q = 2^(LOGQ-1)+1.
// The reduction folds the input into three chunks. Because 2^K is congruent
// to -1 modulo Q, the folded value needs at most one +Q or -Q correction.
module modred_v2 #(
    parameter int LOGQ = 17
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    input  logic [2*LOGQ-1:0]   a,
    output logic                out_valid,
    output logic [LOGQ-1:0]     s
);

    localparam int K = LOGQ - 1;

    // Q = 2^K + 1, held in the same signed LOGQ+1-bit width as t.
    localparam logic signed [LOGQ:0] Q_S = {2'b01, {(K-1){1'b0}}, 1'b1};

    // Input chunks: a = a2*2^(2K) + a1*2^K + a0.
    logic [K-1:0]           w_a0;
    logic [K-1:0]           w_a1;
    logic [1:0]             w_a2;
    logic signed [LOGQ:0]   w_t;
    logic signed [LOGQ:0]   w_corr;

    // Stage-1 and stage-2 pipeline state.
    logic signed [LOGQ:0]   r_t;
    logic                   r_v1;
    logic [LOGQ-1:0]        r_s;
    logic                   r_ov;

    assign w_a0 = a[K-1:0];
    assign w_a1 = a[2*K-1:K];
    assign w_a2 = a[2*K+1:2*K];

    // Fold the three chunks into t = a0 - a1 + a2. The result ranges from
    // -(2^K-1) to 2^K+2, so it fits in LOGQ+1 signed bits.
    always_comb begin
        w_t = $signed({2'b00, w_a0})
            - $signed({2'b00, w_a1})
            + $signed({{K{1'b0}}, w_a2});
    end

    // Bring t into 0..Q-1 with a single conditional correction.
    always_comb begin
        w_corr = r_t;
        if (r_t < $signed({(LOGQ+1){1'b0}})) begin
            w_corr = r_t + Q_S;
        end else if (r_t >= Q_S) begin
            w_corr = r_t - Q_S;
        end else begin
            w_corr = r_t;
        end
    end

    // Stage 1: capture t on accepted inputs and track the stage-1 valid bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_t  <= {(LOGQ+1){1'b0}};
            r_v1 <= 1'b0;
        end else begin
            r_v1 <= in_valid;
            if (in_valid) begin
                r_t <= w_t;
            end else begin
                r_t <= r_t;
            end
        end
    end

    // Stage 2: register the corrected residue. The value holds while idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s  <= {LOGQ{1'b0}};
            r_ov <= 1'b0;
        end else begin
            r_ov <= r_v1;
            if (r_v1) begin
                r_s <= w_corr[LOGQ-1:0];
            end else begin
                r_s <= r_s;
            end
        end
    end

    assign out_valid = r_ov;
    assign s         = r_s;

endmodule

// File: tb/tb_modred_v2.sv
// tb_modred_v2: directed and random checks of modred_v2. Expected residues
// come from plain a % Q arithmetic. A two-cycle delay model supplies
// out_valid timing and the hold value of s.
module tb_modred_v2;

    localparam int    LOGQ = 17;
    localparam longint Q   = 65537;

    logic                clk;
    logic                rst;
    logic                in_valid;
    logic [2*LOGQ-1:0]   a;
    logic                out_valid;
    logic [LOGQ-1:0]     s;

    int n_cmp;
    int n_err;

    // Reference state: the value accepted one edge ago, and what the output shows now.
    logic   m_v1;
    logic   m_v2;
    longint m_e1;
    longint m_s;

    modred_v2 #(.LOGQ(LOGQ)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .a         (a),
        .out_valid (out_valid),
        .s         (s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_v1 = 1'b0;
        m_v2 = 1'b0;
        m_e1 = 0;
        m_s  = 0;
    endtask

    // Drive one cycle of input, advance one edge, and check outputs against the model.
    task automatic step(input logic v, input logic [2*LOGQ-1:0] val);
        in_valid = v;
        a        = val;
        @(posedge clk);
        #1;
        m_v2 = m_v1;
        if (m_v1) m_s = m_e1;
        m_v1 = v;
        if (v) m_e1 = longint'(val) % Q;
        check("out_valid", {63'd0, out_valid}, {63'd0, m_v2});
        check("s", {47'd0, s}, m_s);
    endtask

    // Feed one isolated value and compare the arriving residue with a fixed constant.
    task automatic directed(input string tag, input logic [2*LOGQ-1:0] val, input longint exp);
        step(1'b1, val);
        step(1'b0, 34'd0);
        check({tag, "_valid"}, {63'd0, out_valid}, 64'd1);
        check(tag, {47'd0, s}, exp);
        step(1'b0, 34'd0);
    endtask

    initial begin
        logic [63:0] rnd;
        logic [4:0]  gap;
        n_cmp    = 0;
        n_err    = 0;
        rst      = 1'b1;
        in_valid = 1'b0;
        a        = 34'd0;
        model_reset();
        #1;
        check("reset_out_valid", {63'd0, out_valid}, 64'd0);
        check("reset_s", {47'd0, s}, 64'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Directed values, each with its known residue.
        directed("a_0",        34'd0,                   0);
        directed("a_65536",    34'd65536,               65536);
        directed("a_65537",    34'd65537,               0);
        directed("a_65538",    34'd65538,               1);
        directed("a_2pow32",   34'h1_0000_0000,         1);
        directed("a_neg_t",    34'h0_FFFF_0000,         2);
        directed("a_max",      34'h3_FFFF_FFFF,         3);
        directed("a_sq65536",  34'd4294967296,          1);
        directed("a_12345x54321", 34'd670592745,        18161);

        // Reset with two inputs in flight: clears at once, nothing emerges later.
        rnd = {$urandom(), $urandom()};
        step(1'b1, rnd[33:0]);
        rnd = {$urandom(), $urandom()};
        step(1'b1, rnd[33:0]);
        #2;
        in_valid = 1'b0;
        rst      = 1'b1;
        #1;
        check("midrst_out_valid", {63'd0, out_valid}, 64'd0);
        check("midrst_s", {47'd0, s}, 64'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) step(1'b0, 34'd0);

        // Back-to-back random stream.
        for (int i = 0; i < 1000; i++) begin
            rnd = {$urandom(), $urandom()};
            step(1'b1, rnd[33:0]);
        end
        step(1'b0, 34'd0);
        step(1'b0, 34'd0);

        // Gap pattern 1,0,1,1,0.
        gap = 5'b01101;
        for (int i = 0; i < 5; i++) begin
            rnd = {$urandom(), $urandom()};
            step(gap[i], rnd[33:0]);
        end
        step(1'b0, 34'd0);
        step(1'b0, 34'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
